// File: rtl/output_port_bank_if.sv
// Bus-side bundle for output_port_bank: load strobe/select/data in,
// display latches, per-port FIFO drain handshake and overflow status out.
interface output_port_bank_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned SEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);

   logic                          lo;
   logic [SEL_W-1:0]              port_sel;
   logic [WIDTH-1:0]              in_bus;
   logic [NUM_PORTS*WIDTH-1:0]    out_reg;
   logic [NUM_PORTS*WIDTH-1:0]    out_data;
   logic [NUM_PORTS-1:0]          out_valid;
   logic [NUM_PORTS-1:0]          out_ready;
   logic [NUM_PORTS-1:0]          full;
   logic [NUM_PORTS-1:0]          overflow;
   logic [NUM_PORTS-1:0]          ovf_clr;

   // Control unit / consumer side.
   modport master (
      output lo,
      output port_sel,
      output in_bus,
      output out_ready,
      output ovf_clr,
      input  out_reg,
      input  out_data,
      input  out_valid,
      input  full,
      input  overflow
   );

   // Port bank side.
   modport slave (
      input  lo,
      input  port_sel,
      input  in_bus,
      input  out_ready,
      input  ovf_clr,
      output out_reg,
      output out_data,
      output out_valid,
      output full,
      output overflow
   );

endinterface

// File: rtl/output_port_bank.sv
// Bank of NUM_PORTS output ports. Each port has a display latch holding the
// last value written and a DEPTH-entry first-word-fall-through FIFO drained
// over valid/ready. DEPTH must be a power of two and at least 2.
module output_port_bank #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned SEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 clk,
   input  logic                 clear_n,
   output_port_bank_if.slave    bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [NUM_PORTS-1:0][WIDTH-1:0] w_reg_arr;
   logic [NUM_PORTS-1:0][WIDTH-1:0] w_data_arr;
   logic [NUM_PORTS-1:0]            w_valid_vec;
   logic [NUM_PORTS-1:0]            w_full_vec;
   logic [NUM_PORTS-1:0]            w_ovf_vec;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [WIDTH-1:0] r_reg;
      logic [PTR_W-1:0] r_wptr;
      logic [PTR_W-1:0] r_rptr;
      logic [CNT_W-1:0] r_count;
      logic             r_ovf;

      logic             w_wr;
      logic             w_rd;
      logic             w_valid;
      logic             w_full;
      logic             w_push;
      logic             w_drop;
      logic [CNT_W-1:0] w_count_nxt;

      // Out-of-range selects never match any port, so they are ignored bank-wide.
      assign w_wr    = bus.lo && (bus.port_sel == SEL_W'(p));
      assign w_valid = (r_count != '0);
      assign w_full  = (r_count == CNT_W'(DEPTH));
      assign w_rd    = bus.out_ready[p] && w_valid;
      // A pop on the same edge frees the slot, so a full FIFO still accepts.
      assign w_push  = w_wr && (!w_full || w_rd);
      assign w_drop  = w_wr && w_full && !w_rd;

      // Next occupancy from push/pop combination.
      always_comb begin
         w_count_nxt = r_count;
         if (w_push && !w_rd) begin
            w_count_nxt = r_count + CNT_W'(1);
         end else if (w_rd && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
         end
      end

      // Pointers, count, display latch and sticky overflow flag.
      always_ff @(posedge clk or negedge clear_n) begin
         if (!clear_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_reg   <= '0;
            r_ovf   <= 1'b0;
         end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
               r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_rd) begin
               r_rptr <= r_rptr + PTR_W'(1);
            end
            // The latch always takes the write, even when the FIFO drops it.
            if (w_wr) begin
               r_reg <= bus.in_bus;
            end
            if (w_drop) begin
               r_ovf <= 1'b1;
            end else if (bus.ovf_clr[p]) begin
               r_ovf <= 1'b0;
            end
         end
      end

      // Storage array; contents are meaningless until written, so no reset.
      always_ff @(posedge clk) begin
         if (w_push) begin
            r_mem[r_wptr] <= bus.in_bus;
         end
      end

      // Head is forced to zero while empty so reset leaves out_data at 0.
      assign w_data_arr[p]  = w_valid ? r_mem[r_rptr] : '0;
      assign w_reg_arr[p]   = r_reg;
      assign w_valid_vec[p] = w_valid;
      assign w_full_vec[p]  = w_full;
      assign w_ovf_vec[p]   = r_ovf;
   end : g_port

   assign bus.out_reg   = w_reg_arr;
   assign bus.out_data  = w_data_arr;
   assign bus.out_valid = w_valid_vec;
   assign bus.full      = w_full_vec;
   assign bus.overflow  = w_ovf_vec;

endmodule

// File: tb/tb_output_port_bank.sv
// Directed bench for output_port_bank: two-port main instance plus a
// three-port instance to exercise an out-of-range port_sel.
module tb_output_port_bank;

   logic clk;
   logic clear_n;
   int   n_vec;
   int   n_err;

   output_port_bank_if #(.WIDTH(8), .NUM_PORTS(2), .SEL_W(1)) bus ();
   output_port_bank_if #(.WIDTH(8), .NUM_PORTS(3), .SEL_W(2)) bus3 ();

   output_port_bank #(.WIDTH(8), .NUM_PORTS(2), .DEPTH(4), .SEL_W(1)) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus)
   );

   output_port_bank #(.WIDTH(8), .NUM_PORTS(3), .DEPTH(4), .SEL_W(2)) dut3 (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic sel, input logic [7:0] d);
      bus.lo       = 1'b1;
      bus.port_sel = sel;
      bus.in_bus   = d;
      tick();
      bus.lo       = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_q [4];
      n_vec = 0;
      n_err = 0;
      clear_n       = 1'b0;
      bus.lo        = 1'b0;
      bus.port_sel  = '0;
      bus.in_bus    = '0;
      bus.out_ready = '0;
      bus.ovf_clr   = '0;
      bus3.lo        = 1'b0;
      bus3.port_sel  = '0;
      bus3.in_bus    = '0;
      bus3.out_ready = '0;
      bus3.ovf_clr   = '0;
      tick();
      tick();
      chk("rst_out_reg", 32'(bus.out_reg), 32'h0);
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_full", 32'(bus.full), 32'h0);
      chk("rst_ovf", 32'(bus.overflow), 32'h0);
      clear_n = 1'b1;
      tick();

      // First write: visible next cycle, port 1 untouched.
      wr(1'b0, 8'h3C);
      chk("w0_out_reg", 32'(bus.out_reg), 32'h0000_003C);
      chk("w0_valid", 32'(bus.out_valid), 32'h1);
      chk("w0_out_data", 32'(bus.out_data), 32'h0000_003C);
      bus.out_ready = 2'b01;
      tick();
      bus.out_ready = 2'b00;
      chk("w0_popped", 32'(bus.out_valid), 32'h0);
      chk("w0_latch_kept", 32'(bus.out_reg), 32'h0000_003C);

      // Fill port 1, then overflow it.
      wr(1'b1, 8'h11);
      wr(1'b1, 8'h22);
      wr(1'b1, 8'h33);
      wr(1'b1, 8'h44);
      chk("p1_full", 32'(bus.full), 32'h2);
      chk("p1_head", 32'(bus.out_data[15:8]), 32'h11);
      wr(1'b1, 8'h55);
      chk("p1_ovf", 32'(bus.overflow), 32'h2);
      chk("p1_latch55", 32'(bus.out_reg[15:8]), 32'h55);
      chk("p1_full_kept", 32'(bus.full), 32'h2);
      chk("p1_head_kept", 32'(bus.out_data[15:8]), 32'h11);

      // Dropped write and clear on the same edge: set wins.
      bus.ovf_clr = 2'b10;
      wr(1'b1, 8'h66);
      chk("ovf_set_wins", 32'(bus.overflow), 32'h2);
      chk("p1_latch66", 32'(bus.out_reg[15:8]), 32'h66);
      tick();
      bus.ovf_clr = 2'b00;
      chk("ovf_cleared", 32'(bus.overflow), 32'h0);

      // Drain port 1 in order.
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      bus.out_ready = 2'b10;
      for (int i = 0; i < 4; i++) begin
         chk("p1_drain_valid", 32'(bus.out_valid[1]), 32'h1);
         chk("p1_drain_data", 32'(bus.out_data[15:8]), 32'(exp_q[i]));
         tick();
      end
      bus.out_ready = 2'b00;
      chk("p1_empty", 32'(bus.out_valid), 32'h0);
      chk("p1_not_full", 32'(bus.full), 32'h0);

      // Port 0 full, simultaneous write and pop.
      wr(1'b0, 8'hA0);
      wr(1'b0, 8'hA1);
      wr(1'b0, 8'hA2);
      wr(1'b0, 8'hA3);
      chk("p0_full", 32'(bus.full), 32'h1);
      bus.out_ready = 2'b01;
      wr(1'b0, 8'hA4);
      chk("p0_wr_pop_no_ovf", 32'(bus.overflow), 32'h0);
      chk("p0_wr_pop_full", 32'(bus.full), 32'h1);
      exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      for (int i = 0; i < 4; i++) begin
         chk("p0_drain_data", 32'(bus.out_data[7:0]), 32'(exp_q[i]));
         tick();
      end
      bus.out_ready = 2'b00;
      chk("p0_empty", 32'(bus.out_valid), 32'h0);

      // Streaming through pointer wrap; occupancy stays at one.
      bus.out_ready = 2'b01;
      for (int k = 0; k < 10; k++) begin
         wr(1'b0, 8'(k));
         chk("stream_data", 32'(bus.out_data[7:0]), 32'(k));
         chk("stream_valid", 32'(bus.out_valid), 32'h1);
         chk("stream_not_full", 32'(bus.full), 32'h0);
      end
      tick();
      bus.out_ready = 2'b00;
      chk("stream_done", 32'(bus.out_valid), 32'h0);

      // Async reset mid-drain: port 0 full, port 1 with two entries left.
      wr(1'b0, 8'hC0);
      wr(1'b0, 8'hC1);
      wr(1'b0, 8'hC2);
      wr(1'b0, 8'hC3);
      wr(1'b1, 8'hB0);
      wr(1'b1, 8'hB1);
      wr(1'b1, 8'hB2);
      bus.out_ready = 2'b10;
      tick();
      chk("pre_rst_valid", 32'(bus.out_valid), 32'h3);
      chk("pre_rst_full", 32'(bus.full), 32'h1);
      chk("pre_rst_head1", 32'(bus.out_data[15:8]), 32'hB1);
      #2;
      clear_n = 1'b0;
      #1;
      chk("async_valid", 32'(bus.out_valid), 32'h0);
      chk("async_out_reg", 32'(bus.out_reg), 32'h0);
      chk("async_full", 32'(bus.full), 32'h0);
      chk("async_out_data", 32'(bus.out_data), 32'h0);
      bus.out_ready = 2'b00;
      tick();
      clear_n = 1'b1;
      tick();
      chk("post_rst_valid", 32'(bus.out_valid), 32'h0);

      // Out-of-range select on the three-port instance changes nothing.
      bus3.lo       = 1'b1;
      bus3.port_sel = 2'd3;
      bus3.in_bus   = 8'hFF;
      tick();
      bus3.lo = 1'b0;
      chk("oor_out_reg", 32'(bus3.out_reg), 32'h0);
      chk("oor_valid", 32'(bus3.out_valid), 32'h0);
      chk("oor_ovf", 32'(bus3.overflow), 32'h0);
      bus3.lo       = 1'b1;
      bus3.port_sel = 2'd2;
      bus3.in_bus   = 8'h5A;
      tick();
      bus3.lo = 1'b0;
      chk("p2_out_reg", 32'(bus3.out_reg), 32'h005A_0000);
      chk("p2_valid", 32'(bus3.out_valid), 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
